// File: rtl/ahb_data_memory.sv
// ahb_data_memory: AHB-Lite subordinate around a word-organised 32-bit data SRAM.
// Latency: zero wait states; write commits at the data-phase edge, read data is combinational from the registered address.
// Backpressure: HREADYOUT drops only for the first cycle of a two-cycle ERROR (AHB_MEM_ERR_EN builds); otherwise always ready.
// Build option: `define AHB_MEM_ERR_EN enables illegal-transfer detection; undefined wraps/aligns addresses and never errors.
module ahb_data_memory #(
  parameter int MEM_DEPTH = 32768
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] HADDR,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [1:0]  HTRANS,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;

  // Preloadable storage; deliberately never reset.
  logic [31:0] mem [0:MEM_DEPTH-1];

  state_t        state;
  logic [AW-1:0] idx_q;
  logic [3:0]    lane_q;
  logic          write_q;

  logic          xfer_vld;
  logic          illegal;
  logic [31:0]   word_idx;
  logic [AW-1:0] idx_d;
  logic [3:0]    lane_d;

  // Address-phase decode: transfer qualification, word index, byte lanes and legality.
  always_comb begin
    xfer_vld = HREADY & HTRANS[1];
    word_idx = {2'b00, HADDR[31:2]};
`ifdef AHB_MEM_ERR_EN
    illegal = (word_idx >= 32'(MEM_DEPTH)) ||
              (HSIZE > 3'd2) ||
              ((HSIZE == 3'd1) && HADDR[0]) ||
              ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
    idx_d   = word_idx[AW-1:0];
`else
    // No error path: wrap the index and let the lane mask align down.
    illegal = 1'b0;
    idx_d   = AW'(word_idx % 32'(MEM_DEPTH));
`endif
    case (HSIZE)
      3'd0:    lane_d = 4'b0001 << HADDR[1:0];
      3'd1:    lane_d = HADDR[1] ? 4'b1100 : 4'b0011;
      default: lane_d = 4'b1111;  // word, and oversize treated as word
    endcase
  end

  // Transfer FSM with registered handshake outputs and address-phase capture.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      idx_q     <= '0;
      lane_q    <= '0;
      write_q   <= 1'b0;
    end else begin
      case (state)
        ERR1: begin
          // Bus is stalled here, so any address phase shown now is not sampled.
          state     <= ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b1;
        end
        default: begin
          if (xfer_vld && !illegal) begin
            state     <= DATA;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            idx_q     <= idx_d;
            lane_q    <= lane_d;
            write_q   <= HWRITE;
          end else if (xfer_vld) begin
            state     <= ERR1;
            HREADYOUT <= 1'b0;
            HRESP     <= 1'b1;
          end else begin
            state     <= IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
          end
        end
      endcase
    end
  end

  // Commit write lanes at the end of a write data phase; reset aborts the commit.
  always_ff @(posedge HCLK) begin
    if (!HRESET && (state == DATA) && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_q[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  // Full word read from the registered index; zero outside a read data phase.
  always_comb begin
    HRDATA = 32'h0;
    if ((state == DATA) && !write_q) HRDATA = mem[idx_q];
  end

endmodule

// File: tb/tb_ahb_data_memory.sv
// Directed bench for ahb_data_memory: single master, HREADY fed back from HREADYOUT.
module tb_ahb_data_memory;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] HADDR;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [1:0]  HTRANS;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] rdat;
  logic        rrdy;
  logic        rrsp;
  logic [31:0] exp100;

  ahb_data_memory #(.MEM_DEPTH(32768)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HADDR     (HADDR),
    .HSIZE     (HSIZE),
    .HWRITE    (HWRITE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HTRANS    (HTRANS),
    .HRDATA    (HRDATA),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP)
  );

  assign HREADY = HREADYOUT;

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    HADDR = a; HSIZE = sz; HWRITE = 1'b1; HTRANS = 2'd2;
    tick;
    HTRANS = 2'd0; HWRITE = 1'b0; HWDATA = d;
    tick;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic rdy, output logic rsp);
    HADDR = a; HSIZE = 3'd2; HWRITE = 1'b0; HTRANS = 2'd2;
    tick;
    HTRANS = 2'd0;
    d = HRDATA; rdy = HREADYOUT; rsp = HRESP;
    tick;
  endtask

`ifdef AHB_MEM_ERR_EN
  // Issue one transfer expected to error and check both ERROR cycles.
  task automatic err_xfer(input string tag, input logic [31:0] a, input logic [2:0] sz, input logic w);
    HADDR = a; HSIZE = sz; HWRITE = w; HTRANS = 2'd2;
    tick;
    chk({tag, "_c1_rdy"}, {31'b0, HREADYOUT}, 32'd0);
    chk({tag, "_c1_resp"}, {31'b0, HRESP}, 32'd1);
    // Address phase during the stall must be ignored.
    HADDR = 32'h100; HSIZE = 3'd2; HWRITE = 1'b1; HWDATA = 32'hFFFF_FFFF;
    tick;
    chk({tag, "_c2_rdy"}, {31'b0, HREADYOUT}, 32'd1);
    chk({tag, "_c2_resp"}, {31'b0, HRESP}, 32'd1);
    HTRANS = 2'd0; HWRITE = 1'b0;
    tick;
    chk({tag, "_after_resp"}, {31'b0, HRESP}, 32'd0);
  endtask
`endif

  initial begin
    HRESET = 1'b1; HADDR = '0; HSIZE = 3'd2; HWRITE = 1'b0; HWDATA = '0; HTRANS = 2'd0;
    repeat (2) tick;
    chk("rst_hreadyout", {31'b0, HREADYOUT}, 32'd1);
    chk("rst_hresp", {31'b0, HRESP}, 32'd0);
    chk("rst_hrdata", HRDATA, 32'd0);
    HRESET = 1'b0;
    tick;

    wr(32'h100, 3'd2, 32'hDEAD_BEEF);
    rd(32'h100, rdat, rrdy, rrsp);
    chk("word_rd", rdat, 32'hDEAD_BEEF);
    chk("word_rd_rdy", {31'b0, rrdy}, 32'd1);
    chk("word_rd_resp", {31'b0, rrsp}, 32'd0);

    wr(32'h101, 3'd0, 32'h0000_AB00);
    rd(32'h100, rdat, rrdy, rrsp);
    chk("byte_wr", rdat, 32'hDEAD_ABEF);

    wr(32'h102, 3'd1, 32'h1234_0000);
    rd(32'h100, rdat, rrdy, rrsp);
    chk("half_wr", rdat, 32'h1234_ABEF);
    exp100 = 32'h1234_ABEF;

    // Write immediately followed by a read of the same word.
    HADDR = 32'h200; HSIZE = 3'd2; HWRITE = 1'b1; HTRANS = 2'd2;
    tick;
    chk("b2b_wr_phase_hrdata", HRDATA, 32'd0);
    HWDATA = 32'h55AA_55AA; HWRITE = 1'b0;
    tick;
    HTRANS = 2'd0;
    chk("b2b_rd", HRDATA, 32'h55AA_55AA);
    chk("b2b_rd_rdy", {31'b0, HREADYOUT}, 32'd1);
    tick;
    chk("idle_hrdata", HRDATA, 32'd0);

    // IDLE and BUSY transfers must not write.
    wr(32'h300, 3'd2, 32'h0BAD_C0DE);
    HADDR = 32'h300; HWRITE = 1'b1; HTRANS = 2'd0;
    tick;
    HWDATA = 32'hFFFF_FFFF; HTRANS = 2'd1;
    chk("idle_wr_resp", {31'b0, HRESP}, 32'd0);
    chk("idle_wr_rdy", {31'b0, HREADYOUT}, 32'd1);
    tick;
    HTRANS = 2'd0; HWRITE = 1'b0;
    tick;
    rd(32'h300, rdat, rrdy, rrsp);
    chk("idle_wr_nochange", rdat, 32'h0BAD_C0DE);

`ifdef AHB_MEM_ERR_EN
    err_xfer("err_oob_rd", 32'h2_0000, 3'd2, 1'b0);
    err_xfer("err_misalign_wr", 32'h102, 3'd2, 1'b1);
    rd(32'h100, rdat, rrdy, rrsp);
    chk("err_misalign_nochange", rdat, 32'h1234_ABEF);
    err_xfer("err_size_wr", 32'h100, 3'd3, 1'b1);
    rd(32'h100, rdat, rrdy, rrsp);
    chk("err_size_nochange", rdat, 32'h1234_ABEF);
`else
    wr(32'h0, 3'd2, 32'hCAFE_F00D);
    rd(32'h2_0000, rdat, rrdy, rrsp);
    chk("wrap_rd", rdat, 32'hCAFE_F00D);
    chk("wrap_rd_rdy", {31'b0, rrdy}, 32'd1);
    chk("wrap_rd_resp", {31'b0, rrsp}, 32'd0);
    wr(32'h102, 3'd2, 32'h89AB_CDEF);
    rd(32'h100, rdat, rrdy, rrsp);
    chk("align_down_wr", rdat, 32'h89AB_CDEF);
    exp100 = 32'h89AB_CDEF;
    wr(32'h204, 3'd3, 32'h1357_9BDF);
    rd(32'h204, rdat, rrdy, rrsp);
    chk("size3_as_word", rdat, 32'h1357_9BDF);
`endif

    // Reset during a write data phase aborts the write.
    HADDR = 32'h100; HSIZE = 3'd2; HWRITE = 1'b1; HTRANS = 2'd2;
    tick;
    HTRANS = 2'd0; HWRITE = 1'b0; HWDATA = 32'h1111_1111;
    HRESET = 1'b1;
    #1;
    chk("midrst_rdy", {31'b0, HREADYOUT}, 32'd1);
    chk("midrst_hrdata", HRDATA, 32'd0);
    tick;
    HRESET = 1'b0;
    tick;
    rd(32'h100, rdat, rrdy, rrsp);
    chk("midrst_nowrite", rdat, exp100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
